adder_acc: RTL and testbench
============================

# adder_acc

Registered accumulator directly downstream of the combinational `adder`. It takes each `suma` result through a valid/ready handshake and sums M consecutive accepted samples into a widened register. It then presents the batch total on a valid/ready output port. It is the first clocked stage after the adder and converts its free-running combinational result into a framed, flow-controlled stream.

## Interface
- `N`, default 3: operand width of the upstream adder; `suma` is N+1 bits.
- `M`, default 4: samples per batch; legal range is M ≥ 1.
- `W`, default N+1+$clog2(M), derived, not overridden: width of the accumulator and of `acc_out`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `suma`  in  N+1  sample from the adder, unsigned.
- `in_valid`  in  1  `suma` is valid this cycle.
- `in_ready`  out  1  block accepts a sample this cycle.
- `acc_out`  out  W  batch total, unsigned.
- `out_valid`  out  1  `acc_out` holds a completed batch.
- `out_ready`  in  1  consumer takes `acc_out` this cycle.
- `clr`  in  1  synchronous batch abort; present only with `ADDER_ACC_CLR_EN`.

## Operation
- FSM with two states, ACUM and DONE. On reset: state=ACUM, acc=0, cnt=0, `acc_out`=0, `out_valid`=0.
- `in_ready` = (state==ACUM). It is combinational from state only and never depends on `in_valid`.
- Accept = `in_valid` && `in_ready`. On accept in ACUM:
  - If cnt<M-1: acc += zero-extended `suma`, then cnt++.
  - If cnt==M-1: `acc_out` <= acc+`suma`, acc<=0, cnt<=0, `out_valid`<=1, state<=DONE.
- No accept (`in_valid`=0): acc and cnt hold. Gaps inside a batch are legal and unlimited.
- DONE: `in_ready`=0. `acc_out` and `out_valid` are held stable until `out_valid` && `out_ready`. The cycle after that: `out_valid`=0, state=ACUM. `acc_out` keeps its last value; it is don't-care while `out_valid`=0, but the bench expects it held.
- Arithmetic is unsigned. W bits cannot overflow because M·(2^(N+1)−1) < 2^W. No wrap or saturation logic exists.
- M=1: every accept goes directly to DONE with `acc_out`=`suma`.
- `rst_n` asserted mid-batch or in DONE: all state returns to reset values immediately (asynchronous). The partial batch is discarded with no output.

## Timing
- `acc_out`/`out_valid` are registered. `out_valid` rises one clock after the M-th accept edge.
- Minimum batch period is M+1 cycles: M accepts plus 1 DONE cycle when `out_ready`=1.
- `in_ready` drops in the same cycle `out_valid` rises. It returns high the cycle after the output handshake.
- No combinational path from `in_valid` or `out_ready` to any output.

## Configuration
- `ADDER_ACC_CLR_EN` defined: adds the `clr` port. `clr`=1 at a clock edge forces acc=0, cnt=0, `out_valid`=0, state=ACUM, and overrides any simultaneous accept or output handshake. `acc_out` is unchanged.
- Not defined: no `clr` port. A batch ends only on the M-th accept or on reset.

## Test plan
All scenarios use N=3, M=4, W=6.
- Reset then idle: `acc_out`=0, `out_valid`=0, `in_ready`=1 for 10 cycles.
- Back-to-back samples 2,5,7,14 with `out_ready`=1 → `out_valid`=1 for one cycle with `acc_out`=28. `in_ready` is 0 in that cycle and 1 the next.
- Samples 15,15,15,15 with `in_valid` gaps of 0–3 cycles → `acc_out`=60 and no overflow. The following batch 1,1,1,1 → 4, which confirms acc was cleared.
- `out_ready`=0 for 5 cycles after batch 3,3,3,3 → `acc_out`=12 and `out_valid`=1 held stable, `in_ready`=0, and `in_valid` pulses are ignored. After `out_ready`=1, the next batch sum is correct.
- `rst_n` pulsed low after 2 of 4 samples (values 6,6) → outputs go to 0 asynchronously. The next batch 1,2,3,4 → 10.
- With `ADDER_ACC_CLR_EN`: `clr` after samples 9,9 and then samples 1,1,1,1 → `acc_out`=4. `clr` asserted in DONE → `out_valid` falls without a handshake.

Source files
------------

// File: rtl/adder_acc.sv
// adder_acc: batches M accepted adder samples into a widened total and
// presents it on a valid/ready output port.
// Optional feature: `ADDER_ACC_CLR_EN adds a synchronous batch-abort input clr.
module adder_acc #(
   parameter  int N = 3,
   parameter  int M = 4,
   localparam int W = N + 1 + $clog2(M)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N:0]   suma,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] acc_out,
   output logic         out_valid,
`ifdef ADDER_ACC_CLR_EN
   input  logic         clr,
`endif
   input  logic         out_ready
);

   // Counter must hold 0..M-1; keep at least one bit so M=1 still elaborates.
   localparam int          CW   = (M > 1) ? $clog2(M) : 1;
   localparam logic [CW-1:0] LAST = CW'(M - 1);

   typedef enum logic {ACUM, DONE} state_t;

   state_t        state, state_nx;
   logic [W-1:0]  acc;
   logic [CW-1:0] cnt;
   logic          accept, last, abort;

`ifdef ADDER_ACC_CLR_EN
   assign abort = clr;
`else
   assign abort = 1'b0;
`endif

   // Ready depends on state only, so no path from in_valid reaches an output.
   assign in_ready = (state == ACUM);
   assign accept   = in_valid && in_ready;
   assign last     = (cnt == LAST);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ACUM;
      else        state <= state_nx;
   end

   // Next state: close the batch on the M-th accept, reopen after the output handshake.
   always_comb begin
      state_nx = state;
      case (state)
         ACUM: if (accept && last) state_nx = DONE;
         DONE: if (out_ready)      state_nx = ACUM;
         default:                  state_nx = ACUM;
      endcase
      if (abort) state_nx = ACUM;
   end

   // Datapath: accumulate, emit the batch total, drop valid after the handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         cnt       <= '0;
         acc_out   <= '0;
         out_valid <= 1'b0;
      end else if (abort) begin
         // Abort discards the partial batch and any pending result; acc_out is left as is.
         acc       <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
      end else begin
         if (accept) begin
            if (last) begin
               acc_out   <= acc + W'(suma);
               acc       <= '0;
               cnt       <= '0;
               out_valid <= 1'b1;
            end else begin
               acc <= acc + W'(suma);
               cnt <= cnt + 1'b1;
            end
         end
         if (state == DONE && out_ready) out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adder_acc.sv
// tb_adder_acc: directed scenarios plus random batches, scoreboarded against
// a sum-of-M-samples reference model.
module tb_adder_acc;

   localparam int N = 3;
   localparam int M = 4;
   localparam int W = 6;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N:0]   suma = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] acc_out;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic         clr_t = 1'b0;

   int total = 0;
   int bad = 0;
   bit rand_rdy = 1'b0;

   int unsigned exp_q[$];   // expected batch totals, oldest first
   int unsigned batch[$];   // accepted samples of the batch in progress

   always #5 clk = ~clk;

   adder_acc #(.N(N), .M(M)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .suma(suma),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .acc_out(acc_out),
      .out_valid(out_valid),
`ifdef ADDER_ACC_CLR_EN
      .clr(clr_t),
`endif
      .out_ready(out_ready)
   );

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge; optionally randomise out_ready.
   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
   endtask

   // Offer one sample until it is accepted, then update the reference model.
   task automatic send(input int unsigned v);
      bit took;
      int guard;
      int unsigned s;
      in_valid = 1'b1;
      suma     = (N+1)'(v);
      took     = 1'b0;
      guard    = 0;
      while (!took && guard < 200) begin
         @(negedge clk);
         took = in_ready;
         tick();
         guard++;
      end
      in_valid = 1'b0;
      if (!took) begin
         chk("send_timeout", 0, 1);
      end else begin
         batch.push_back(v);
         if (batch.size() == M) begin
            s = 0;
            foreach (batch[i]) s += batch[i];
            exp_q.push_back(s);
            batch.delete();
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Monitor: pop and compare on each output handshake; check held outputs stay put.
   bit           hold_pend = 1'b0;
   logic [W-1:0] hold_val;
   always @(negedge clk) begin
      if (rst_n) begin
         if (hold_pend) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", acc_out, hold_val);
         end
         hold_pend = out_valid && !out_ready && !clr_t;
         hold_val  = acc_out;
         if (out_valid && out_ready && !clr_t) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", acc_out, 32'hFFFF_FFFF);
            end else begin
               chk("batch_sum", acc_out, exp_q.pop_front());
            end
         end
      end else begin
         hold_pend = 1'b0;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      // Reset state before any edge.
      #2;
      chk("rst_acc_out", acc_out, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle after reset.
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_acc_out", acc_out, 0);
         chk("idle_out_valid", out_valid, 0);
         chk("idle_in_ready", in_ready, 1);
      end

      // Back-to-back batch, output visible the edge after the 4th accept.
      out_ready = 1'b1;
      send(2); send(5); send(7); send(14);
      chk("b2b_out_valid", out_valid, 1);
      chk("b2b_acc_out", acc_out, 28);
      chk("b2b_in_ready_low", in_ready, 0);
      tick();
      chk("b2b_out_valid_fall", out_valid, 0);
      chk("b2b_in_ready_back", in_ready, 1);

      // Max samples with gaps, then a small batch to confirm clearing.
      for (int i = 0; i < 4; i++) begin
         send(15);
         idle(int'($urandom_range(0, 3)));
      end
      idle(2);
      chk("max_no_overflow", acc_out, 60);
      send(1); send(1); send(1); send(1);
      idle(2);

      // Stalled consumer: result held, inputs ignored.
      out_ready = 1'b0;
      send(3); send(3); send(3); send(3);
      for (int i = 0; i < 5; i++) begin
         chk("stall_out_valid", out_valid, 1);
         chk("stall_acc_out", acc_out, 12);
         chk("stall_in_ready", in_ready, 0);
         in_valid = i[0];
         suma     = 4'd7;
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      send(2); send(2); send(2); send(2);
      idle(2);

      // Asynchronous reset mid-batch.
      send(6); send(6);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_acc_out", acc_out, 0);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_in_ready", in_ready, 1);
      batch.delete();
      exp_q.delete();
      #10;
      rst_n = 1'b1;
      tick();
      send(1); send(2); send(3); send(4);
      idle(2);
      chk("after_reset_sum", acc_out, 10);

`ifdef ADDER_ACC_CLR_EN
      // Abort mid-batch, then a fresh batch.
      send(9); send(9);
      clr_t = 1'b1;
      tick();
      clr_t = 1'b0;
      batch.delete();
      send(1); send(1); send(1); send(1);
      idle(2);
      chk("clr_batch_sum", acc_out, 4);
      // Abort while holding a result.
      out_ready = 1'b0;
      send(5); send(5); send(5); send(5);
      chk("clr_done_valid_pre", out_valid, 1);
      clr_t = 1'b1;
      tick();
      clr_t = 1'b0;
      void'(exp_q.pop_back());
      chk("clr_done_valid", out_valid, 0);
      chk("clr_done_in_ready", in_ready, 1);
      chk("clr_done_acc_kept", acc_out, 20);
      out_ready = 1'b1;
      tick();
`endif

      // Random batches with random gaps and random consumer backpressure.
      rand_rdy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         send($urandom_range(0, 15));
         idle(int'($urandom_range(0, 2)));
      end
      rand_rdy  = 1'b0;
      out_ready = 1'b1;
      g = 0;
      while (exp_q.size() != 0 && g < 50) begin
         tick();
         g++;
      end
      idle(2);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
